io_device_router: RTL and testbench

- Downstream neighbour of the multi-core bus arbiter. Takes its single serialized device-bus request and routes it to one of DEV_NUMS memory-mapped I/O slaves (UART, CLINT, timer, GPIO, ...).
- Decodes the address, strobes exactly one slave, waits for that slave's ready, and returns the read data upstream as a one-cycle ready pulse.
- Unmapped addresses and hung slaves are answered with an error response, so the arbiter never deadlocks.

---
 rtl/io_device_router.sv | 137 +++++++++++++
 tb/tb_io_device_router.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/io_device_router.sv
// Routes one serialized device-bus request to a memory-mapped I/O slave and returns its data upstream.
// Latency: unmapped T+1, slave ready in ISSUE T+2, k-th WAIT cycle T+2+k, timeout T+1+TIMEOUT_CYCLES.
// Backpressure: one request outstanding; S_strobe_i is ignored outside IDLE; hung slaves answered by timeout.
module io_device_router #(
    parameter int               XLEN           = 32,
    parameter int               DEV_NUMS       = 4,
    parameter logic [3:0]       IO_TAG         = 4'hC,
    parameter int               TIMEOUT_CYCLES = 256,
    parameter logic [XLEN-1:0]  ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 S_strobe_i,
    input  logic [XLEN-1:0]      S_addr_i,
    input  logic                 S_rw_i,
    input  logic [XLEN/8-1:0]    S_byte_enable_i,
    input  logic [XLEN-1:0]      S_data_i,
    output logic                 S_data_ready_o,
    output logic [XLEN-1:0]      S_data_o,
    output logic [DEV_NUMS-1:0]  D_strobe_o,
    output logic [XLEN-1:0]      D_addr_o,
    output logic                 D_rw_o,
    output logic [XLEN/8-1:0]    D_byte_enable_o,
    output logic [XLEN-1:0]      D_data_o,
    input  logic [DEV_NUMS-1:0]  D_data_ready_i,
    input  logic [XLEN-1:0]      D_data_i [0:DEV_NUMS-1],
    output logic                 bus_err_o,
    output logic [XLEN-1:0]      err_addr_o
);
    localparam int IDX_W = (DEV_NUMS > 1) ? $clog2(DEV_NUMS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         dev_idx_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               load_req, resp_ok, resp_err;

    logic [3:0]         in_idx;
    logic               in_hit;
    logic [IDX_W-1:0]   dev_sel;
    logic               sel_rdy;

    assign in_idx  = S_addr_i[XLEN-5:XLEN-8];
    assign in_hit  = (S_addr_i[XLEN-1:XLEN-4] == IO_TAG) && (32'(in_idx) < DEV_NUMS);
    // dev_sel only matters in ISSUE/WAIT, where the latched index is known to be in range
    assign dev_sel = dev_idx_q[IDX_W-1:0];
    assign sel_rdy = D_data_ready_i[dev_sel];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        resp_ok  = 1'b0;
        resp_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (S_strobe_i) begin
                    load_req = 1'b1;
                    if (in_hit) begin
                        state_d = ISSUE;
                    end else begin
                        state_d  = RESP;
                        resp_err = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (sel_rdy) begin
                    state_d = RESP;
                    resp_ok = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (sel_rdy) begin
                    state_d = RESP;
                    resp_ok = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = RESP;
                    resp_err = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter reads 0 in ISSUE and k in the k-th WAIT cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            D_addr_o        <= '0;
            D_rw_o          <= 1'b0;
            D_byte_enable_o <= '0;
            D_data_o        <= '0;
            dev_idx_q       <= '0;
            err_q           <= 1'b0;
            cnt_q           <= '0;
            S_data_o        <= '0;
            err_addr_o      <= '0;
        end else begin
            if (load_req) begin
                D_addr_o        <= S_addr_i;
                D_rw_o          <= S_rw_i;
                D_byte_enable_o <= S_byte_enable_i;
                D_data_o        <= S_data_i;
                dev_idx_q       <= in_idx;
            end
            if (state_q == ISSUE || state_q == WAIT) cnt_q <= cnt_q + 1'b1;
            else                                     cnt_q <= '0;
            if (resp_ok) begin
                S_data_o <= D_data_i[dev_sel];
                err_q    <= 1'b0;
            end else if (resp_err) begin
                S_data_o <= ERR_DATA;
                err_q    <= 1'b1;
            end
            if (state_q == RESP && err_q) err_addr_o <= D_addr_o;
        end
    end

    always_comb begin
        D_strobe_o = '0;
        for (int i = 0; i < DEV_NUMS; i++)
            D_strobe_o[i] = (state_q == ISSUE) && (dev_idx_q == 4'(i));
    end

    assign S_data_ready_o = (state_q == RESP);
    assign bus_err_o      = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_io_device_router.sv
// Directed bench for io_device_router: decode, slave handshake, unmapped/timeout errors and mid-flight reset.
module tb_io_device_router;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        S_strobe_i;
    logic [31:0] S_addr_i;
    logic        S_rw_i;
    logic [3:0]  S_byte_enable_i;
    logic [31:0] S_data_i;
    logic        S_data_ready_o;
    logic [31:0] S_data_o;
    logic [3:0]  D_strobe_o;
    logic [31:0] D_addr_o;
    logic        D_rw_o;
    logic [3:0]  D_byte_enable_o;
    logic [31:0] D_data_o;
    logic [3:0]  D_data_ready_i;
    logic [31:0] D_data_i [0:3];
    logic        bus_err_o;
    logic [31:0] err_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    io_device_router dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .S_strobe_i(S_strobe_i), .S_addr_i(S_addr_i), .S_rw_i(S_rw_i),
        .S_byte_enable_i(S_byte_enable_i), .S_data_i(S_data_i),
        .S_data_ready_o(S_data_ready_o), .S_data_o(S_data_o),
        .D_strobe_o(D_strobe_o), .D_addr_o(D_addr_o), .D_rw_o(D_rw_o),
        .D_byte_enable_o(D_byte_enable_o), .D_data_o(D_data_o),
        .D_data_ready_i(D_data_ready_i), .D_data_i(D_data_i),
        .bus_err_o(bus_err_o), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request in cycle T; returns positioned in cycle T+1
    task automatic req(input logic [31:0] a, input logic rw, input logic [3:0] be, input logic [31:0] d);
        S_addr_i        = a;
        S_rw_i          = rw;
        S_byte_enable_i = be;
        S_data_i        = d;
        S_strobe_i      = 1'b1;
        tick();
        S_strobe_i      = 1'b0;
    endtask

    initial begin
        int n;
        logic early;
        rst_ni = 1'b0;
        S_strobe_i = 1'b0; S_addr_i = '0; S_rw_i = 1'b0; S_byte_enable_i = '0; S_data_i = '0;
        D_data_ready_i = '0;
        for (int i = 0; i < 4; i++) D_data_i[i] = 32'h0;
        tick(); tick();
        check("rst_ready",  {31'b0, S_data_ready_o}, 32'h0);
        check("rst_err",    {31'b0, bus_err_o},      32'h0);
        check("rst_strobe", {28'b0, D_strobe_o},     32'h0);
        check("rst_addr",   D_addr_o,                32'h0);
        check("rst_sdata",  S_data_o,                32'h0);
        check("rst_erraddr", err_addr_o,             32'h0);
        rst_ni = 1'b1;
        tick();

        // Read slave1, ready in first WAIT cycle
        D_data_i[1] = 32'h1234_5678;
        req(32'hC100_0004, 1'b0, 4'hF, 32'h0);
        check("t1_strobe_T1", {28'b0, D_strobe_o}, 32'h2);
        check("t1_addr",      D_addr_o,            32'hC100_0004);
        check("t1_ready_T1",  {31'b0, S_data_ready_o}, 32'h0);
        tick();
        check("t1_strobe_T2", {28'b0, D_strobe_o}, 32'h0);
        check("t1_ready_T2",  {31'b0, S_data_ready_o}, 32'h0);
        D_data_ready_i[1] = 1'b1;
        tick();
        D_data_ready_i[1] = 1'b0;
        check("t1_ready_T3",  {31'b0, S_data_ready_o}, 32'h1);
        check("t1_data",      S_data_o,            32'h1234_5678);
        check("t1_err",       {31'b0, bus_err_o},  32'h0);
        tick();
        check("t1_ready_off", {31'b0, S_data_ready_o}, 32'h0);
        check("t1_data_hold", S_data_o,            32'h1234_5678);

        // Write slave0, ready already high in ISSUE
        D_data_ready_i[0] = 1'b1;
        D_data_i[0] = 32'h55AA_0011;
        req(32'hC000_0000, 1'b1, 4'b0011, 32'hAABB_CCDD);
        check("t2_strobe",  {28'b0, D_strobe_o}, 32'h1);
        check("t2_rw",      {31'b0, D_rw_o},     32'h1);
        check("t2_be",      {28'b0, D_byte_enable_o}, 32'h3);
        check("t2_wdata",   D_data_o,            32'hAABB_CCDD);
        check("t2_ready_T1", {31'b0, S_data_ready_o}, 32'h0);
        tick();
        D_data_ready_i[0] = 1'b0;
        check("t2_ready_T2", {31'b0, S_data_ready_o}, 32'h1);
        check("t2_data",     S_data_o,            32'h55AA_0011);
        check("t2_strobe_T2", {28'b0, D_strobe_o}, 32'h0);
        check("t2_addr_stable", D_addr_o,         32'hC000_0000);
        tick();

        // Unmapped: wrong tag, then out-of-range device index
        req(32'h8000_0010, 1'b0, 4'hF, 32'h0);
        check("t3a_strobe", {28'b0, D_strobe_o},     32'h0);
        check("t3a_ready",  {31'b0, S_data_ready_o}, 32'h1);
        check("t3a_data",   S_data_o,                32'hDEAD_BEEF);
        check("t3a_err",    {31'b0, bus_err_o},      32'h1);
        tick();
        check("t3a_erraddr", err_addr_o,             32'h8000_0010);
        check("t3a_err_off", {31'b0, bus_err_o},     32'h0);
        req(32'hC500_0000, 1'b1, 4'hF, 32'h0);
        check("t3b_strobe", {28'b0, D_strobe_o},     32'h0);
        check("t3b_ready",  {31'b0, S_data_ready_o}, 32'h1);
        check("t3b_err",    {31'b0, bus_err_o},      32'h1);
        tick();
        check("t3b_erraddr", err_addr_o,             32'hC500_0000);

        // Slave2 hangs: timeout response at T+257, then normal access to slave0
        req(32'hC200_0000, 1'b0, 4'hF, 32'h0);
        n = 1;
        while (S_data_ready_o !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("t4_latency", n,                    32'd257);
        check("t4_data",    S_data_o,             32'hDEAD_BEEF);
        check("t4_err",     {31'b0, bus_err_o},   32'h1);
        tick();
        check("t4_erraddr", err_addr_o,           32'hC200_0000);
        D_data_ready_i[0] = 1'b1;
        D_data_i[0] = 32'h0BAD_F00D;
        req(32'hC000_0040, 1'b0, 4'hF, 32'h0);
        tick();
        check("t4_follow_ready", {31'b0, S_data_ready_o}, 32'h1);
        check("t4_follow_data",  S_data_o,                32'h0BAD_F00D);
        check("t4_follow_err",   {31'b0, bus_err_o},      32'h0);
        tick();

        // Slave3 ready on the timeout cycle (T+256); slave0 ready is spurious
        req(32'hC300_0008, 1'b0, 4'hF, 32'h0);
        early = 1'b0;
        repeat (255) begin
            tick();
            if (S_data_ready_o !== 1'b0) early = 1'b1;
        end
        check("t5_no_early", {31'b0, early}, 32'h0);
        D_data_ready_i[3] = 1'b1;
        D_data_i[3] = 32'hCAFE_0003;
        tick();
        D_data_ready_i = '0;
        check("t5_ready", {31'b0, S_data_ready_o}, 32'h1);
        check("t5_data",  S_data_o,                32'hCAFE_0003);
        check("t5_err",   {31'b0, bus_err_o},      32'h0);
        tick();
        check("t5_erraddr_kept", err_addr_o,       32'hC200_0000);

        // Reset while waiting on slave2
        req(32'hC200_0004, 1'b1, 4'h5, 32'h7777_8888);
        tick();
        rst_ni = 1'b0;
        #1;
        check("t6_rst_strobe",  {28'b0, D_strobe_o}, 32'h0);
        check("t6_rst_addr",    D_addr_o,            32'h0);
        check("t6_rst_wdata",   D_data_o,            32'h0);
        check("t6_rst_sdata",   S_data_o,            32'h0);
        check("t6_rst_erraddr", err_addr_o,          32'h0);
        tick();
        rst_ni = 1'b1;
        early = 1'b0;
        repeat (10) begin
            tick();
            if (S_data_ready_o !== 1'b0 || bus_err_o !== 1'b0) early = 1'b1;
        end
        check("t6_no_stale", {31'b0, early}, 32'h0);
        D_data_ready_i[1] = 1'b1;
        D_data_i[1] = 32'h0000_BEEF;
        req(32'hC100_0000, 1'b0, 4'hF, 32'h0);
        check("t6_new_strobe", {28'b0, D_strobe_o}, 32'h2);
        tick();
        D_data_ready_i = '0;
        check("t6_new_ready", {31'b0, S_data_ready_o}, 32'h1);
        check("t6_new_data",  S_data_o,                32'h0000_BEEF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
